// File: rtl/lfsr_prbs_gen_if.sv
// rtl/lfsr_prbs_gen_if.sv - control, PRBS word stream and status bundle for lfsr_prbs_gen
//
// Signals:
//   load       seed-load pulse (consumer/controller -> generator)
//   load_seed  seed captured on load
//   out_ready  consumer accepts out_data
//   out_valid  out_data holds a complete word
//   out_data   packed PRBS word, first-generated bit in the MSB
//   lfsr_state current LFSR register
//   wrap       pulse: sequence returned to the seed of record
//   seed_sub   pulse: a zero seed was replaced by SEED
// Modports: master = generator side, slave = controller/consumer side.
interface lfsr_prbs_gen_if #(
    parameter int WIDTH = 13,
    parameter int OUT_W = 1
);
    logic             load;
    logic [WIDTH-1:0] load_seed;
    logic             out_ready;
    logic             out_valid;
    logic [OUT_W-1:0] out_data;
    logic [WIDTH-1:0] lfsr_state;
    logic             wrap;
    logic             seed_sub;

    modport master (
        input  load, load_seed, out_ready,
        output out_valid, out_data, lfsr_state, wrap, seed_sub
    );

    modport slave (
        output load, load_seed, out_ready,
        input  out_valid, out_data, lfsr_state, wrap, seed_sub
    );
endinterface

// File: rtl/lfsr_prbs_gen.sv
// rtl/lfsr_prbs_gen.sv - parametrised Fibonacci LFSR PRBS generator with word packing and handshake
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  lfsr_prbs_gen_if.master: load/load_seed, out_ready in;
//        out_valid/out_data, lfsr_state, wrap, seed_sub out
// The LFSR only advances when the output register can take a new bit, so a
// stalled consumer freezes the sequence and no generated bit is ever lost.
module lfsr_prbs_gen #(
    parameter int               WIDTH = 13,
    parameter logic [WIDTH-1:0] TAPS  = 13'h1C80,
    parameter logic [WIDTH-1:0] SEED  = 13'h0001,
    parameter int               OUT_W = 1
) (
    input  logic            clk,
    input  logic            rst,
    lfsr_prbs_gen_if.master bus
);
    if (SEED == '0) begin : g_seed_zero
        $error("lfsr_prbs_gen: SEED must be nonzero");
    end
    if (WIDTH < 2 || WIDTH > 32) begin : g_width_range
        $error("lfsr_prbs_gen: WIDTH must be 2..32");
    end
    if (OUT_W < 1 || OUT_W > WIDTH) begin : g_out_w_range
        $error("lfsr_prbs_gen: OUT_W must be 1..WIDTH");
    end

    localparam int               CNT_W    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_W - 1);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] seed_rec_q;   // seed of record, reference for wrap
    logic [OUT_W-1:0] acc_q;
    logic [OUT_W-1:0] data_q;
    logic [CNT_W-1:0] cnt_q;
    logic             valid_q;
    logic             wrap_q;
    logic             sub_q;

    logic             fb;
    logic             shift_en;
    logic             word_done;
    logic [WIDTH-1:0] state_nx;
    logic [OUT_W-1:0] acc_nx;
    logic [WIDTH-1:0] load_val;

    always_comb begin
        fb        = ^(state_q & TAPS);
        state_nx  = {state_q[WIDTH-2:0], fb};
        // Truncating cast keeps the low OUT_W bits, which also covers OUT_W==1.
        acc_nx    = OUT_W'({acc_q, fb});
        // valid_q && !out_ready is the only stall condition.
        shift_en  = !valid_q || bus.out_ready;
        word_done = shift_en && (cnt_q == CNT_LAST);
        load_val  = (bus.load_seed == '0) ? SEED : bus.load_seed;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SEED;
            seed_rec_q <= SEED;
            acc_q      <= '0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            wrap_q     <= 1'b0;
            sub_q      <= 1'b0;
        end else if (bus.load) begin
            // Any pending word is dropped, even if it is being accepted now.
            state_q    <= load_val;
            seed_rec_q <= load_val;
            sub_q      <= (bus.load_seed == '0);
            acc_q      <= '0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            wrap_q     <= 1'b0;
        end else if (state_q == '0) begin
            // All-zero is a fixed point of the LFSR; recover to SEED.
            state_q    <= SEED;
            sub_q      <= 1'b1;
            wrap_q     <= 1'b0;
        end else begin
            sub_q  <= 1'b0;
            wrap_q <= shift_en && (state_nx == seed_rec_q);
            if (shift_en) begin
                state_q <= state_nx;
                acc_q   <= acc_nx;
                if (word_done) begin
                    data_q  <= acc_nx;
                    valid_q <= 1'b1;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                    // shift_en with valid_q set means the word was taken.
                    if (valid_q) begin
                        valid_q <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.out_valid  = valid_q;
    assign bus.out_data   = data_q;
    assign bus.lfsr_state = state_q;
    assign bus.wrap       = wrap_q;
    assign bus.seed_sub   = sub_q;
endmodule

// File: doc/lfsr_prbs_gen.md
Name: lfsr_prbs_gen

Overview:
Parametrised Fibonacci LFSR pseudo-random bit generator for the ASK transmit path.
- Generalises the fixed 13-bit single-bit LFSR to any width and tap set.
- Adds runtime seed load and zero-seed protection.
- Packs OUT_W generated bits into a word and presents it on a valid/ready handshake, stalling the LFSR under backpressure.
- Emits a wrap pulse each time the sequence returns to its seed, for period checking and frame alignment.

Parameters:
- WIDTH, 13: LFSR register width, 2..32.
- TAPS, 13'h1C80: feedback mask, bit i set means state[i] is XORed into feedback. Default is x^13+x^12+x^11+x^8+1, i.e. bits 12, 11, 10, 7.
- SEED, 1: reset seed and zero-substitute seed. Must be nonzero; a zero value is an elaboration error.
- OUT_W, 1: bits per output word, 1..WIDTH.

Ports:
- clk, input, 1: the block's one clock; all logic is on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- load, input, 1: single-cycle pulse that loads load_seed.
- load_seed, input, WIDTH: seed value captured on load.
- out_ready, input, 1: consumer accepts out_data.
- out_valid, output, 1: out_data holds a complete word.
- out_data, output, OUT_W: packed PRBS word. The first-generated bit is in the MSB.
- lfsr_state, output, WIDTH: current LFSR register.
- wrap, output, 1: one-cycle pulse when a shift returns lfsr_state to the seed of record.
- seed_sub, output, 1: one-cycle pulse when a zero load_seed was replaced by SEED.

Behaviour:
- Feedback:
  - fb = XOR-reduce(lfsr_state & TAPS).
  - Shift: lfsr_state <= {lfsr_state[WIDTH-2:0], fb}.
  - The generated bit is fb.
- Shift enable: shift_en = !out_valid || (out_valid && out_ready).
  - The LFSR advances exactly on shift_en cycles.
  - It holds while out_valid=1 and out_ready=0.
- Packing, with internal accumulator acc[OUT_W-1:0] and counter cnt:
  - On each shift: acc <= {acc[OUT_W-2:0], fb}, cnt <= cnt+1.
  - On a shift with cnt==OUT_W-1: out_data <= {acc[OUT_W-2:0], fb}, out_valid <= 1, cnt <= 0.
  - On a handshake (out_valid && out_ready) that does not complete a new word: out_valid <= 0.
  - Consequences:
    - OUT_W=1 with out_ready held high gives out_valid=1 every cycle with a new bit each cycle.
    - OUT_W=N with out_ready held high gives one word every N cycles.
    - Latency from reset or load to the first out_valid is OUT_W cycles.
- out_data is stable while out_valid=1 and out_ready=0.
- Seed of record:
  - Set to SEED on reset.
  - Set to the loaded value on load.
  - wrap asserts in the cycle after a shift whose next state equals the seed of record.
  - For the default parameters, wrap has period 8191 shifts.
- Reset (rst=1), outputs the following cycle:
  - lfsr_state=SEED, out_valid=0, out_data=0, wrap=0, seed_sub=0.
  - acc=0, cnt=0.
- Load (load=1, rst=0):
  - lfsr_state <= (load_seed==0) ? SEED : load_seed.
  - seed_sub <= (load_seed==0).
  - acc=0, cnt=0, out_valid=0, out_data unchanged.
  - A word pending on out_valid is discarded even if out_ready=1 in the same cycle.
  - No shift occurs in the load cycle.
- Priority: rst > load > shift/handshake.
- Lockup guard: if lfsr_state is ever 0 without load or rst, the next cycle forces SEED and pulses seed_sub. This cannot occur in normal operation and is present for safety.
- wrap and seed_sub are single-cycle registered pulses, 0 otherwise.

Test Plan:
1. Defaults, OUT_W=8, after rst, out_ready=1:
   - first out_valid on cycle 8 with out_data=8'h01 and lfsr_state=13'h0101.
   - Generated bits 1-7 are 0 and bit 8 is 1.
2. Defaults, OUT_W=1, out_ready=1 for 8191 cycles:
   - wrap pulses exactly once, on shift 8191, with lfsr_state=13'h0001.
   - No other repeat of 13'h0001 occurs.
3. Backpressure, OUT_W=8: hold out_ready=0 for 20 cycles after the first out_valid.
   - out_data stays 8'h01 and lfsr_state stays 13'h0101.
   - After out_ready is raised, the next word arrives 8 cycles later.
4. load=1, load_seed=13'h0000 while out_valid=1, out_ready=1:
   - Next cycle: lfsr_state=13'h0001, seed_sub=1, out_valid=0.
   - The pending word is not counted as accepted.
5. load=1 with load_seed=13'h1ABC:
   - wrap fires after 8191 shifts at 13'h1ABC.
   - A simultaneous rst=1 wins, giving lfsr_state=13'h0001.
6. Reference model: run 10,000 words each for WIDTH=7/TAPS=7'h60, OUT_W=3 and for WIDTH=16, OUT_W=16 against a software LFSR model, with random out_ready.
   - All words match in order, with no drops or duplicates.
